// File: rtl/oled_spi_receiver.sv
// oled_spi_receiver: receiving end of the write-only 4-wire OLED SPI link.
// Deserializes bytes and decodes page-addressing commands into a frame buffer.
// Ports:
//   sys_clk, rst_n                          : system clock, async active-low reset
//   oled_csn/rst/dcn/clk/data               : raw serial link inputs (synchronized here)
//   byte_valid, byte_data, byte_is_data     : received byte strobe, value and D/C flag
//   rd_page, rd_col, rd_data                : frame buffer read port (1-cycle latency)
//   cur_page, cur_col, display_on, contrast : decoded controller state
module oled_spi_receiver #(
    parameter int PAGES = 8,
    parameter int COLS  = 128
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       oled_csn,
    input  logic       oled_rst,
    input  logic       oled_dcn,
    input  logic       oled_clk,
    input  logic       oled_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    input  logic [2:0] rd_page,
    input  logic [6:0] rd_col,
    output logic [7:0] rd_data,
    output logic [2:0] cur_page,
    output logic [6:0] cur_col,
    output logic       display_on,
    output logic [7:0] contrast
);

    typedef enum logic {
        IDLE = 1'b0,
        ARG  = 1'b1
    } state_t;

    // Idle levels of {csn, rst, dcn, clk, data}; all five lines share one
    // synchronizer so their relative alignment survives.
    localparam logic [4:0] SYNC_IDLE = 5'b11010;

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic       clk_prev;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    logic csn_s;
    logic prst_s;
    logic dcn_s;
    logic clk_s;
    logic dat_s;
    logic rise;

    assign csn_s  = sync2[4];
    assign prst_s = sync2[3];
    assign dcn_s  = sync2[2];
    assign clk_s  = sync2[1];
    assign dat_s  = sync2[0];

    // csn high in the same synced cycle as a clk rise drops the bit.
    assign rise = clk_s & ~clk_prev & ~csn_s;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_IDLE;
            sync2 <= SYNC_IDLE;
        end else begin
            sync1 <= {oled_csn, oled_rst, oled_dcn, oled_clk, oled_data};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_prev     <= 1'b1;
            shreg        <= 8'h00;
            bit_cnt      <= 3'd0;
            byte_valid   <= 1'b0;
            byte_data    <= 8'h00;
            byte_is_data <= 1'b0;
        end else begin
            clk_prev   <= clk_s;
            byte_valid <= 1'b0;
            if (!prst_s || csn_s) begin
                bit_cnt <= 3'd0;
            end else if (rise) begin
                shreg   <= {shreg[6:0], dat_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid   <= 1'b1;
                    byte_data    <= {shreg[6:0], dat_s};
                    byte_is_data <= dcn_s;
                end
            end
        end
    end

    // Command decoder: acts on the byte while byte_valid is high, so the
    // pointers move at the edge that ends the byte_valid cycle.
    state_t     state;
    state_t     nxt_state;
    logic       arg_ctr;
    logic       nxt_arg_ctr;
    logic [2:0] nxt_page;
    logic [6:0] nxt_col;
    logic       nxt_disp;
    logic [7:0] nxt_contrast;
    logic       fb_we;
    logic [6:0] col_inc;
    logic       one_arg;

    assign col_inc = (cur_col == 7'(COLS - 1)) ? 7'd0 : cur_col + 7'd1;
    assign one_arg = byte_data inside {8'h20, 8'h8D, 8'hA8, 8'hD3,
                                       8'hD5, 8'hD9, 8'hDA, 8'hDB};

    always_comb begin
        nxt_state    = state;
        nxt_arg_ctr  = arg_ctr;
        nxt_page     = cur_page;
        nxt_col      = cur_col;
        nxt_disp     = display_on;
        nxt_contrast = contrast;
        fb_we        = 1'b0;
        if (!prst_s) begin
            nxt_state    = IDLE;
            nxt_arg_ctr  = 1'b0;
            nxt_page     = 3'd0;
            nxt_col      = 7'd0;
            nxt_disp     = 1'b0;
            nxt_contrast = 8'h7F;
        end else if (byte_valid) begin
            if (byte_is_data) begin
                // Data never consumes a pending argument.
                fb_we   = 1'b1;
                nxt_col = col_inc;
            end else if (state == ARG) begin
                if (arg_ctr) begin
                    nxt_contrast = byte_data;
                end
                nxt_state   = IDLE;
                nxt_arg_ctr = 1'b0;
            end else begin
                unique case (1'b1)
                    byte_data[7:4] == 4'h0: nxt_col[3:0] = byte_data[3:0];
                    byte_data[7:4] == 4'h1: nxt_col[6:4] = byte_data[2:0];
                    byte_data[7:4] == 4'hB: nxt_page = byte_data[2:0];
                    byte_data[7:1] == 7'h57: nxt_disp = byte_data[0];
                    byte_data == 8'h81: begin
                        nxt_state   = ARG;
                        nxt_arg_ctr = 1'b1;
                    end
                    one_arg: nxt_state = ARG;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            arg_ctr    <= 1'b0;
            cur_page   <= 3'd0;
            cur_col    <= 7'd0;
            display_on <= 1'b0;
            contrast   <= 8'h7F;
        end else begin
            state      <= nxt_state;
            arg_ctr    <= nxt_arg_ctr;
            cur_page   <= nxt_page;
            cur_col    <= nxt_col;
            display_on <= nxt_disp;
            contrast   <= nxt_contrast;
        end
    end

    // Frame buffer: plain RAM, deliberately not reset; read-first.
    logic [7:0] fb [PAGES*COLS];

    always_ff @(posedge sys_clk) begin
        if (fb_we) begin
            fb[{cur_page, cur_col}] <= byte_data;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= fb[{rd_page, rd_col}];
        end
    end

endmodule
